sw_debounce: RTL

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 114 +++++++++++
 1 files changed

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
//
// Whole-word switch debouncer with a CPU change handshake.
//
// The raw switch word is synchronised through two flops. A candidate word
// follows the synchronised value. A stability counter measures how long the
// synchronised value has matched the candidate. Once the candidate has held
// long enough and differs from the published word, the whole word is
// accepted in one edge. sw_changed then tells the CPU to read it.
//
// Ports
//   clock      : single clock, rising-edge active
//   n_reset    : asynchronous, active-low reset
//   sw_raw     : raw switch levels, asynchronous to clock   [WORD_W]
//   sw         : debounced switch word presented to the CPU [WORD_W]
//   sw_changed : set on acceptance of a new word, held until sw_ack
//   sw_ack     : one-cycle pulse from the CPU after it has read sw
//   overrun    : sticky; a new word was accepted while sw_changed was pending
// -----------------------------------------------------------------------------
module sw_debounce #(
  parameter int WORD_W          = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] sw_raw,
  output logic [WORD_W-1:0] sw,
  output logic              sw_changed,
  input  logic              sw_ack,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WORD_W-1:0] sync1_q, sync1_d;
  logic [WORD_W-1:0] sync2_q, sync2_d;
  logic [WORD_W-1:0] cand_q,  cand_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [WORD_W-1:0] sw_q,    sw_d;
  logic              changed_q, changed_d;
  logic              overrun_q, overrun_d;
  logic              accept;

  // The candidate has been stable for the full window and would actually
  // change the published word. A value that settles back to the current sw
  // never accepts, so it cannot raise sw_changed.
  assign accept = (cnt_q == CNT_MAX) && (sync2_q == cand_q) && (cand_q != sw_q);

  always_comb begin
    sync1_d   = sw_raw;
    sync2_d   = sync1_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    sw_d      = sw_q;
    changed_d = changed_q;
    overrun_d = overrun_q;

    // Any movement of the synchronised word restarts the stability window.
    // The counter saturates so a long-held value keeps satisfying accept.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (accept) begin
      sw_d = cand_q;
    end

    // Set wins over clear. An ack that coincides with acceptance still
    // leaves a fresh, unread word pending.
    if (accept) begin
      changed_d = 1'b1;
    end else if (sw_ack) begin
      changed_d = 1'b0;
    end

    // Overrun means an unread word was overwritten. If the CPU acks on the
    // same edge, the previous word was read in time.
    if (accept && changed_q && !sw_ack) begin
      overrun_d = 1'b1;
    end else if (sw_ack) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      sw_q      <= '0;
      changed_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= changed_d;
      overrun_q <= overrun_d;
    end
  end

  assign sw         = sw_q;
  assign sw_changed = changed_q;
  assign overrun    = overrun_q;

endmodule
